// File: rtl/imu_pkt_uart_tx_if.sv
// imu_pkt_uart_tx_if: upstream payload byte stream feeding imu_pkt_uart_tx.
//   pl_valid  source -> sink  payload byte valid
//   pl_data   source -> sink  payload byte
//   pl_ready  sink -> source  byte accepted when pl_valid & pl_ready
// master: byte source (upstream); slave: byte sink (the UART packet transmitter).
interface imu_pkt_uart_tx_if;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;

  modport master (
    output pl_valid,
    output pl_data,
    input  pl_ready
  );

  modport slave (
    input  pl_valid,
    input  pl_data,
    output pl_ready
  );
endinterface

// File: rtl/imu_pkt_uart_tx.sv
// imu_pkt_uart_tx: serialises one IMU packet per start pulse onto a UART line
// (8N1, LSB first, idle high). A packet is the two header bytes
// (IMU_PKT_HEADER[15:8] first) followed by payload bytes pulled from the
// upstream stream, IMU_PKT_SIZE bytes in total, then GAP_BITS idle bit-times.
//
// Ports:
//   sys_clk  in   system clock
//   reset    in   asynchronous, active-high reset; aborts any packet at once
//   start    in   single-cycle request to send one packet (sampled in IDLE only)
//   pl       if   payload stream sink (pl_valid, pl_data in; pl_ready out)
//   uart_tx  out  serial line, driven from a flop
//   busy     out  high while a packet is in progress
//   done     out  one-cycle pulse at the end of the inter-packet gap
//
// Build option: define IMU_TX_CHECKSUM_EN to replace the final payload byte
// with the modulo-256 sum of the pulled payload bytes (header excluded).
module imu_pkt_uart_tx #(
  parameter int unsigned CLKS_PER_BIT   = 54,
  parameter int unsigned IMU_PKT_SIZE   = 46,
  parameter logic [15:0] IMU_PKT_HEADER = 16'h5AA5,
  parameter int unsigned GAP_BITS       = 10
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  imu_pkt_uart_tx_if.slave        pl,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [5:0]  LAST_BYTE = 6'(IMU_PKT_SIZE - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_BITS - 1);
  localparam bit          HAS_GAP   = (GAP_BITS != 0);

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [5:0]  byte_cnt;
  logic [15:0] gap_cnt;
  logic [7:0]  data_q;

  logic       baud_last;
  logic       last_byte;
  logic       gap_last;
  logic       load_hdr;
  logic       load_sum;
  logic       load_go;
  logic [7:0] load_byte;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign load_hdr  = (byte_cnt < 6'd2);

`ifdef IMU_TX_CHECKSUM_EN
  logic [7:0] csum;

  assign load_sum = last_byte;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (state == S_IDLE) begin
      csum <= '0;
    end else if (pl.pl_valid && pl.pl_ready) begin
      csum <= csum + pl.pl_data;
    end
  end
`else
  assign load_sum = 1'b0;
`endif

  assign pl.pl_ready = (state == S_LOAD) && !load_hdr && !load_sum;
  assign load_go     = (state == S_LOAD) && (load_hdr || load_sum || pl.pl_valid);
  assign busy        = (state != S_IDLE);
  // With no gap the pulse moves onto the last stop-bit cycle.
  assign done        = baud_last &&
                       (((state == S_GAP) && gap_last) ||
                        (!HAS_GAP && (state == S_STOP) && last_byte));

  always_comb begin
    load_byte = pl.pl_data;
    if (load_hdr) begin
      load_byte = byte_cnt[0] ? IMU_PKT_HEADER[7:0] : IMU_PKT_HEADER[15:8];
    end
`ifdef IMU_TX_CHECKSUM_EN
    else if (load_sum) begin
      load_byte = csum;
    end
`endif
  end

  // uart_tx is updated on the same edge that enters the state producing it,
  // so the registered line level lines up exactly with each state's cycles.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      data_q   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (start) begin
            state    <= S_LOAD;
            byte_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (load_go) begin
            data_q   <= load_byte;
            state    <= S_START;
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
            uart_tx  <= data_q[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              uart_tx <= data_q[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (last_byte) begin
              gap_cnt <= '0;
              state   <= HAS_GAP ? S_GAP : S_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 6'd1;
              state    <= S_LOAD;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            gap_cnt  <= gap_cnt + 16'd1;
            if (gap_last) begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_pkt_uart_tx.sv
// tb_imu_pkt_uart_tx: directed bench for imu_pkt_uart_tx with CLKS_PER_BIT=4,
// GAP_BITS=10, 46-byte packets. Packet scenarios come from a table; the line
// is logged per cycle and decoded afterwards against hand-derived bytes.
module tb_imu_pkt_uart_tx;

  localparam int CPB  = 4;
  localparam int GAPB = 10;
  localparam int PKT  = 46;
`ifdef IMU_TX_CHECKSUM_EN
  localparam int EXP_HS = 43;
`else
  localparam int EXP_HS = 44;
`endif

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic start   = 1'b0;
  logic uart_tx;
  logic busy;
  logic done;

  imu_pkt_uart_tx_if pl_if ();

  imu_pkt_uart_tx #(
    .CLKS_PER_BIT  (CPB),
    .IMU_PKT_SIZE  (PKT),
    .IMU_PKT_HEADER(16'h5AA5),
    .GAP_BITS      (GAPB)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .start  (start),
    .pl     (pl_if),
    .uart_tx(uart_tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string name;
    int    stall_idx;   // payload handshake index at which to stall, -1 = none
    int    stall_len;   // cycles pl_valid is held low
    bit    restart;     // pulse start at cycle 50 and on the done cycle
    int    exp_done;    // expected done cycle, counted from the start-accept cycle
  } scen_t;

  typedef struct {
    int   bit_idx;      // 0 = start bit, 1..8 = data, 9 = stop
    logic exp_tx;
  } bitvec_t;

  scen_t   scen [4];
  bitvec_t first_byte [10];

  int n_cmp = 0;
  int n_bad = 0;

  logic tx_log   [0:2399];
  logic busy_log [0:2399];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] payload(input int i);
`ifdef IMU_TX_CHECKSUM_EN
    return (i >= 0) ? 8'h10 : 8'h10;
`else
    return 8'(i);
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    if (k == 0) return 8'h5A;
    if (k == 1) return 8'hA5;
`ifdef IMU_TX_CHECKSUM_EN
    if (k == PKT - 1) return 8'hB0;
    return 8'h10;
`else
    return 8'(k - 2);
`endif
  endfunction

  task automatic run_packet(input scen_t s);
    int   hs = 0;
    int   idx = 0;
    int   stall_cnt = 0;
    int   stall_bad = 0;
    int   done_cyc = -1;
    int   done_n = 0;
    int   ncyc;
    int   post_bad = 0;
    int   frame_bad = 0;
    bit   pend = 0;
    bit   stalled = 0;
    logic [7:0] q[$];
    ncyc = s.exp_done + 100;
    pl_if.pl_valid = 1'b1;
    pl_if.pl_data  = payload(0);
    @(negedge sys_clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge sys_clk);
      start = s.restart && (c == 50 || c == s.exp_done);
      tx_log[c]   = uart_tx;
      busy_log[c] = busy;
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (pend) begin
        hs++;
        idx++;
        pl_if.pl_data = payload(idx);
      end
      if (stall_cnt > 0) begin
        if (uart_tx !== 1'b1) stall_bad++;
        stall_cnt--;
        if (stall_cnt == 0) pl_if.pl_valid = 1'b1;
      end else if (!stalled && s.stall_idx >= 0 && hs == s.stall_idx && pl_if.pl_ready === 1'b1) begin
        stalled = 1;
        stall_cnt = s.stall_len;
        pl_if.pl_valid = 1'b0;
        if (uart_tx !== 1'b1) stall_bad++;
      end
      pend = pl_if.pl_valid && pl_if.pl_ready;
    end
    start = 1'b0;
    pl_if.pl_valid = 1'b0;

    // exact cycle-level shape of the first byte (0x5A): LOAD at cycle 1, start bit at 2
    for (int b = 0; b < 10; b++) begin
      logic act;
      act = tx_log[2 + 4 * first_byte[b].bit_idx];
      for (int j = 0; j < CPB; j++)
        if (tx_log[2 + 4 * first_byte[b].bit_idx + j] !== first_byte[b].exp_tx)
          act = tx_log[2 + 4 * first_byte[b].bit_idx + j];
      chk($sformatf("%s_byte0_bit%0d", s.name, b), 32'(act), 32'(first_byte[b].exp_tx));
    end
    chk($sformatf("%s_load_tx", s.name), 32'(tx_log[1]), 32'd1);
    chk($sformatf("%s_busy_c1", s.name), 32'(busy_log[1]), 32'd1);

    // decode the logged line, sampling each bit mid-way
    for (int c = 2; c + 37 <= ncyc; c++) begin
      if (tx_log[c] === 1'b0 && tx_log[c - 1] === 1'b1) begin
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = tx_log[c + 4 * (i + 1) + 1];
        if (tx_log[c + 1] !== 1'b0 || tx_log[c + 37] !== 1'b1) frame_bad++;
        q.push_back(v);
        c += 39;
      end
    end
    chk($sformatf("%s_nbytes", s.name), 32'(q.size()), 32'(PKT));
    chk($sformatf("%s_framing", s.name), 32'(frame_bad), 32'd0);
    for (int k = 0; k < PKT && k < q.size(); k++)
      chk($sformatf("%s_byte%0d", s.name, k), 32'(q[k]), 32'(exp_byte(k)));

    chk($sformatf("%s_done_cycle", s.name), 32'(done_cyc), 32'(s.exp_done));
    chk($sformatf("%s_done_count", s.name), 32'(done_n), 32'd1);
    chk($sformatf("%s_busy_at_done", s.name), 32'(busy_log[s.exp_done]), 32'd1);
    chk($sformatf("%s_busy_after_done", s.name), 32'(busy_log[s.exp_done + 1]), 32'd0);
    for (int c = s.exp_done + 1; c <= ncyc; c++)
      if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0) post_bad++;
    chk($sformatf("%s_idle_after_done", s.name), 32'(post_bad), 32'd0);
    chk($sformatf("%s_handshakes", s.name), 32'(hs), 32'(EXP_HS));
    if (s.stall_idx >= 0) begin
      chk($sformatf("%s_stall_entered", s.name), 32'(stalled), 32'd1);
      chk($sformatf("%s_stall_line_idle", s.name), 32'(stall_bad), 32'd0);
    end
  endtask

  initial begin
    int idle_bad;
    scen[0] = '{"plain",       -1,   0, 1'b0, 1926};
    scen[1] = '{"stall6",       4, 100, 1'b0, 2026};
    scen[2] = '{"restart",     -1,   0, 1'b1, 1926};
    scen[3] = '{"stall_first",  0,   7, 1'b0, 1933};
    // 0x5A framed: start 0, data LSB first 0,1,0,1,1,0,1,0, stop 1
    first_byte[0] = '{0, 1'b0};
    first_byte[1] = '{1, 1'b0};
    first_byte[2] = '{2, 1'b1};
    first_byte[3] = '{3, 1'b0};
    first_byte[4] = '{4, 1'b1};
    first_byte[5] = '{5, 1'b1};
    first_byte[6] = '{6, 1'b0};
    first_byte[7] = '{7, 1'b1};
    first_byte[8] = '{8, 1'b0};
    first_byte[9] = '{9, 1'b1};

    pl_if.pl_valid = 1'b0;
    pl_if.pl_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pl_ready", 32'(pl_if.pl_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    idle_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || pl_if.pl_ready !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    chk("rst_idle_hold", 32'(idle_bad), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_packet(scen[i]);
      repeat (5) @(negedge sys_clk);
    end

    // abort mid-byte: cycle 388 is data bit 3 (a 0) of byte index 9 (0x07)
    pl_if.pl_valid = 1'b1;
    pl_if.pl_data  = 8'h07;
    @(negedge sys_clk);
    start = 1'b1;
    for (int c = 1; c <= 388; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
    end
    chk("abort_pre_tx", 32'(uart_tx), 32'd0);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_tx", 32'(uart_tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pl_ready", 32'(pl_if.pl_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    pl_if.pl_valid = 1'b0;
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("abort_idle_tx", 32'(uart_tx), 32'd1);
    run_packet('{"after_abort", -1, 0, 1'b0, 1926});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
